bram_port_arbiter: RTL and testbench
====================================

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
- REQ-001: Parameters, one per line: NUM_COL, 4, byte columns per word; COL_WIDTH, 8, bits per column; ADDR_WIDTH, 14, word address bits; DATA_WIDTH, NUM_COL*COL_WIDTH, word width.
- REQ-002: One clock; reset is asynchronous and active-high. Ports: clk, input, 1, rising-edge clock.
- REQ-003: reset, input, 1, asynchronous active-high reset.
- REQ-004: reqN_valid, input, 1, N in {0,1}: requester N presents an access.
- REQ-005: reqN_ready, output, 1: access accepted this cycle.
- REQ-006: reqN_we, input, NUM_COL: byte write enables; all-zero means read.
- REQ-007: reqN_addr, input, ADDR_WIDTH: word address.
- REQ-008: reqN_wdata, input, DATA_WIDTH: write data.
- REQ-009: rspN_valid, output, 1: read/write completion for requester N.
- REQ-010: rspN_rdata, output, DATA_WIDTH: read data, valid with rspN_valid.
- REQ-011: memC_en, output, 1; memC_we, output, NUM_COL; memC_addr, output, ADDR_WIDTH; memC_din, output, DATA_WIDTH: drive RAM port C.
- REQ-012: memC_dout, input, DATA_WIDTH: RAM port C registered read data.
- REQ-013: portB_en, input, 1; portB_we, input, NUM_COL; portB_addr, input, ADDR_WIDTH: snoop of RAM port B.
- REQ-014: stall_cnt, output, 16: saturating count of collision-blocked cycles.

Function
- REQ-015: Conflict for requester N = portB_en AND reqN_addr==portB_addr AND (|reqN_we OR |portB_we).
- REQ-016: Eligible = reqN_valid AND NOT conflict; at most one eligible requester granted per cycle.
- REQ-017: Granted requester: reqN_ready=1 combinationally; memC_en=1; memC_we/addr/din = that requester's we/addr/wdata, same cycle.
- REQ-018: No grant: memC_en=0, memC_we=0, memC_addr=0, memC_din=0; all reqN_ready=0.
- REQ-019: Accepted access completes exactly 1 cycle later: rspN_valid pulses 1 cycle for the granted N; rspN_rdata=memC_dout (old data for writes, per RAM read-first).
- REQ-020: rspN_rdata SHALL be 0 whenever rspN_valid=0.
- REQ-021: Registered state: last_grant (1 bit), rsp_pending (1 bit), rsp_id (1 bit), stall_cnt.
- REQ-022: Back-to-back grants allowed every cycle; throughput 1 access/cycle.
- REQ-023: stall_cnt increments by 1 each cycle in which any reqN_valid=1 and that requester is conflicted; saturates at 0xFFFF; never wraps.
- REQ-024: Conflicted requester holds its request stable until ready; arbiter never issues a conflicting port C write (RAM would silently drop it).
- REQ-025: Requester may drop valid without ready; no state is affected.

Reset
- REQ-026: While reset=1: all ready, rspN_valid, memC_* outputs = 0 asynchronously; rspN_rdata=0; stall_cnt=0; last_grant=1 (requester 0 wins first tie); rsp_pending=0.
- REQ-027: Reset asserted mid-access cancels the pending response; no rspN_valid after deassertion for pre-reset accesses.

Configuration
- REQ-028: Macro ARB_ROUND_ROBIN_EN.
- REQ-029: Defined: both eligible -> grant the requester not equal to last_grant; last_grant updates to the granted ID on every grant.
- REQ-030: Undefined: fixed priority, requester 0 always wins ties; last_grant unused (held at reset value).

Verification
- REQ-031: Reset, req0 read addr 0x10 (RAM holds 0xDEADBEEF) -> ready0=1 same cycle, rsp0_valid=1 with rdata 0xDEADBEEF next cycle.
- REQ-032: req0 and req1 valid continuously, no conflicts, ARB_ROUND_ROBIN_EN defined -> grants 0,1,0,1; undefined -> 0,0,0,0 with ready1=0.
- REQ-033: req1 write we=4'b0011 addr 0x20 while portB_en=1, portB_addr=0x20 for 3 cycles -> ready1=0, memC_en=0 for 3 cycles, stall_cnt=3, grant on 4th cycle.
- REQ-034: req0 read addr 0x30 while portB read addr 0x30 (portB_we=0) -> no conflict, granted immediately.
- REQ-035: Assert reset the cycle after a grant -> rsp0_valid stays 0 through and after reset; stall_cnt=0.
- REQ-036: Force 0x10000 conflicted cycles -> stall_cnt holds 0xFFFF.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// bram_port_arbiter
//
// Shares one port (C) of a true dual-port block RAM between two requesters.
// The other RAM port (B) belongs to a foreign master; the arbiter snoops it
// and holds back any requester whose access would collide with it on the
// same word while either side writes. Colliding port writes on this RAM
// family are silently dropped, so such an access must never be issued.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  defined   : round-robin between two eligible requesters
//                       undefined : fixed priority, requester 0 wins ties
//
// Ports
//   clk, reset                    clock, asynchronous active-high reset
//   reqN_valid/ready              access handshake, N in {0,1}; ready is
//                                 combinational in the cycle of the grant
//   reqN_we/addr/wdata            byte write enables (all-zero = read),
//                                 word address, write data
//   rspN_valid/rdata              completion one cycle after the grant; rdata
//                                 is the RAM's read-first output, 0 when idle
//   memC_en/we/addr/din           drive of RAM port C (all zero when idle)
//   memC_dout                     registered read data of RAM port C
//   portB_en/we/addr              snoop of RAM port B
//   stall_cnt                     saturating count of collision-blocked cycles
// ---------------------------------------------------------------------------
module bram_port_arbiter #(
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [NUM_COL-1:0]    req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [NUM_COL-1:0]    req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,

  output logic                  memC_en,
  output logic [NUM_COL-1:0]    memC_we,
  output logic [ADDR_WIDTH-1:0] memC_addr,
  output logic [DATA_WIDTH-1:0] memC_din,
  input  logic [DATA_WIDTH-1:0] memC_dout,

  input  logic                  portB_en,
  input  logic [NUM_COL-1:0]    portB_we,
  input  logic [ADDR_WIDTH-1:0] portB_addr,

  output logic [15:0]           stall_cnt
);

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  logic conflict0, conflict1;
  logic elig0, elig1;
  logic grant0, grant1, grantAny;
  logic stallEvent;

  logic        lastGrant;   // ID of the most recently granted requester
  logic        rspPending;  // an access was granted last cycle
  logic        rspId;       // which requester that access belongs to
  logic [15:0] stallCnt;

  // -------------------------------------------------------------------------
  // Collision detection and grant selection
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default before any branch so
  // that no path leaves it unassigned, which would infer a latch.
  always_comb begin
    conflict0 = portB_en && (req0_addr == portB_addr) && ((|req0_we) || (|portB_we));
    conflict1 = portB_en && (req1_addr == portB_addr) && ((|req1_we) || (|portB_we));

    // Reset gates eligibility so ready and the port C drive drop to zero
    // asynchronously, not just at the next edge.
    elig0 = req0_valid && !conflict0 && !reset;
    elig1 = req1_valid && !conflict1 && !reset;

    grant0 = 1'b0;
    grant1 = 1'b0;
    if (elig0 && elig1) begin
      // Round-robin hands the tie to the requester that did not win last;
      // with the feature off requester 0 always takes it.
      if (RR_EN && (lastGrant == 1'b0)) grant1 = 1'b1;
      else                              grant0 = 1'b1;
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
    grantAny = grant0 || grant1;

    // A blocked requester counts whether or not the other one is granted.
    stallEvent = (req0_valid && conflict0) || (req1_valid && conflict1);
  end

  // -------------------------------------------------------------------------
  // Port C drive: the granted requester's fields, all zero when idle
  // -------------------------------------------------------------------------
  always_comb begin
    memC_en   = grantAny;
    memC_we   = '0;
    memC_addr = '0;
    memC_din  = '0;
    if (grant0) begin
      memC_we   = req0_we;
      memC_addr = req0_addr;
      memC_din  = req0_wdata;
    end else if (grant1) begin
      memC_we   = req1_we;
      memC_addr = req1_addr;
      memC_din  = req1_wdata;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // -------------------------------------------------------------------------
  // Registered state
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lastGrant  <= 1'b1;   // requester 0 wins the first tie
      rspPending <= 1'b0;   // drops any in-flight completion
      rspId      <= 1'b0;
      stallCnt   <= 16'd0;
    end else begin
      rspPending <= grantAny;
      rspId      <= grant1;
      if (RR_EN && grantAny) begin
        lastGrant <= grant1;
      end
      if (stallEvent && (stallCnt != 16'hFFFF)) begin
        stallCnt <= stallCnt + 16'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Completion: the RAM's registered output lines up with the cycle after
  // the grant, so it is steered straight to the owning requester.
  // -------------------------------------------------------------------------
  assign rsp0_valid = rspPending && (rspId == 1'b0);
  assign rsp1_valid = rspPending && (rspId == 1'b1);
  assign rsp0_rdata = rsp0_valid ? memC_dout : '0;
  assign rsp1_rdata = rsp1_valid ? memC_dout : '0;

  assign stall_cnt = stallCnt;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_port_arbiter
//
// Directed bench for bram_port_arbiter with a behavioural read-first RAM on
// port C. Each step drives inputs at the falling edge, checks grant and
// port C drive shortly after, and pushes the expected completion into a
// scoreboard that the next step pops against rspN_valid/rspN_rdata.
// Expected read data comes from a shadow memory updated from the bench's own
// stimulus. Build with or without ARB_ROUND_ROBIN_EN.
// ---------------------------------------------------------------------------
module tb_bram_port_arbiter;

  localparam int NUM_COL    = 4;
  localparam int COL_WIDTH  = 8;
  localparam int ADDR_WIDTH = 14;
  localparam int DATA_WIDTH = NUM_COL * COL_WIDTH;

  logic                  clk;
  logic                  reset;
  logic                  req0_valid, req0_ready;
  logic [NUM_COL-1:0]    req0_we;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;
  logic                  rsp0_valid;
  logic [DATA_WIDTH-1:0] rsp0_rdata;
  logic                  req1_valid, req1_ready;
  logic [NUM_COL-1:0]    req1_we;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wdata;
  logic                  rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp1_rdata;
  logic                  memC_en;
  logic [NUM_COL-1:0]    memC_we;
  logic [ADDR_WIDTH-1:0] memC_addr;
  logic [DATA_WIDTH-1:0] memC_din;
  logic [DATA_WIDTH-1:0] memC_dout;
  logic                  portB_en;
  logic [NUM_COL-1:0]    portB_we;
  logic [ADDR_WIDTH-1:0] portB_addr;
  logic [15:0]           stall_cnt;

  bram_port_arbiter #(
    .NUM_COL(NUM_COL), .COL_WIDTH(COL_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .memC_en(memC_en), .memC_we(memC_we), .memC_addr(memC_addr),
    .memC_din(memC_din), .memC_dout(memC_dout),
    .portB_en(portB_en), .portB_we(portB_we), .portB_addr(portB_addr),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Initial RAM contents: a recognisable pattern plus 0xDEADBEEF at 0x10.
  function automatic logic [31:0] initWord(input int a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return 32'hC0DE0000 | (a & 32'h3FFF);
  endfunction

  // Behavioural RAM port C: registered, read-first, byte write enables.
  logic [31:0] ram [int];
  logic [31:0] ramCur, ramNxt;
  always @(posedge clk) begin
    if (memC_en) begin
      ramCur = ram.exists(int'(memC_addr)) ? ram[int'(memC_addr)] : initWord(int'(memC_addr));
      ramNxt = ramCur;
      for (int c = 0; c < NUM_COL; c++) begin
        if (memC_we[c]) ramNxt[c*COL_WIDTH +: COL_WIDTH] = memC_din[c*COL_WIDTH +: COL_WIDTH];
      end
      ram[int'(memC_addr)] = ramNxt;
      memC_dout <= ramCur;
    end
  end

  // Shadow memory and scoreboard, driven only from the bench's stimulus.
  typedef struct {
    logic        id;
    logic [31:0] data;
  } exp_t;

  exp_t        sbQ [$];
  logic [31:0] shadow [int];

  int testCnt = 0;
  int failCnt = 0;

  function automatic logic [31:0] shadowRead(input int a);
    return shadow.exists(a) ? shadow[a] : initWord(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive0(input logic v, input logic [3:0] we, input logic [13:0] a, input logic [31:0] d);
    req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
  endtask

  task automatic drive1(input logic v, input logic [3:0] we, input logic [13:0] a, input logic [31:0] d);
    req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
  endtask

  task automatic driveB(input logic en, input logic [3:0] we, input logic [13:0] a);
    portB_en = en; portB_we = we; portB_addr = a;
  endtask

  // One cycle: check last cycle's completion, check this cycle's grant
  // (expGrant = -1 for none), record the expected completion, then advance
  // to the next falling edge.
  task automatic step(input int expGrant, input string tag);
    exp_t        e;
    logic [3:0]  we;
    logic [13:0] a;
    logic [31:0] d, old, nw;
    #1;
    if (sbQ.size() != 0) begin
      e = sbQ.pop_front();
      check({tag, " rsp0_valid"}, 32'(rsp0_valid), 32'(e.id == 1'b0));
      check({tag, " rsp1_valid"}, 32'(rsp1_valid), 32'(e.id == 1'b1));
      check({tag, " rsp rdata"}, e.id ? rsp1_rdata : rsp0_rdata, e.data);
      check({tag, " idle rdata"}, e.id ? rsp0_rdata : rsp1_rdata, 32'h0);
    end else begin
      check({tag, " rsp0_valid"}, 32'(rsp0_valid), 32'h0);
      check({tag, " rsp1_valid"}, 32'(rsp1_valid), 32'h0);
      check({tag, " rsp0_rdata"}, rsp0_rdata, 32'h0);
      check({tag, " rsp1_rdata"}, rsp1_rdata, 32'h0);
    end
    check({tag, " ready0"}, 32'(req0_ready), 32'(expGrant == 0));
    check({tag, " ready1"}, 32'(req1_ready), 32'(expGrant == 1));
    check({tag, " memC_en"}, 32'(memC_en), 32'(expGrant >= 0));
    if (expGrant >= 0) begin
      we = (expGrant == 1) ? req1_we    : req0_we;
      a  = (expGrant == 1) ? req1_addr  : req0_addr;
      d  = (expGrant == 1) ? req1_wdata : req0_wdata;
      check({tag, " memC_we"},   32'(memC_we),   32'(we));
      check({tag, " memC_addr"}, 32'(memC_addr), 32'(a));
      check({tag, " memC_din"},  memC_din,       d);
      old = shadowRead(int'(a));
      nw  = old;
      for (int c = 0; c < NUM_COL; c++) begin
        if (we[c]) nw[c*8 +: 8] = d[c*8 +: 8];
      end
      shadow[int'(a)] = nw;
      e.id   = (expGrant == 1);
      e.data = old;
      sbQ.push_back(e);
    end else begin
      check({tag, " memC_we"},   32'(memC_we),   32'h0);
      check({tag, " memC_addr"}, 32'(memC_addr), 32'h0);
      check({tag, " memC_din"},  memC_din,       32'h0);
    end
    @(negedge clk);
  endtask

  initial begin
    // ---- Reset: requests presented during reset are ignored --------------
    reset = 1'b1;
    drive0(1'b1, 4'h0, 14'h10, 32'h0);
    drive1(1'b1, 4'hF, 14'h11, 32'h12345678);
    driveB(1'b0, 4'h0, 14'h0);
    @(negedge clk);
    @(negedge clk);
    check("rst ready0",     32'(req0_ready), 32'h0);
    check("rst ready1",     32'(req1_ready), 32'h0);
    check("rst memC_en",    32'(memC_en),    32'h0);
    check("rst memC_addr",  32'(memC_addr),  32'h0);
    check("rst memC_din",   memC_din,        32'h0);
    check("rst rsp0_valid", 32'(rsp0_valid), 32'h0);
    check("rst rsp1_valid", 32'(rsp1_valid), 32'h0);
    check("rst rsp0_rdata", rsp0_rdata,      32'h0);
    check("rst stall_cnt",  32'(stall_cnt),  32'h0);
    drive0(1'b0, 4'h0, 14'h0, 32'h0);
    drive1(1'b0, 4'h0, 14'h0, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // ---- Both requesters continuously valid, no collisions ---------------
    drive0(1'b1, 4'h0, 14'h50, 32'h0);
    drive1(1'b1, 4'h0, 14'h60, 32'h0);
`ifdef ARB_ROUND_ROBIN_EN
    step(0, "rr g1");
    step(1, "rr g2");
    step(0, "rr g3");
    step(1, "rr g4");
`else
    step(0, "fp g1");
    step(0, "fp g2");
    step(0, "fp g3");
    step(0, "fp g4");
`endif
    drive0(1'b0, 4'h0, 14'h0, 32'h0);
    drive1(1'b0, 4'h0, 14'h0, 32'h0);
    step(-1, "both drain");

    // ---- Single read of a preloaded word ---------------------------------
    drive0(1'b1, 4'h0, 14'h10, 32'h0);
    step(0, "rd10");
    drive0(1'b0, 4'h0, 14'h0, 32'h0);
    #1 check("rd10 beef", rsp0_rdata, 32'hDEADBEEF);
    step(-1, "rd10 rsp");

    // ---- Partial write followed by read-back -----------------------------
    drive1(1'b1, 4'b0011, 14'h40, 32'h11223344);
    step(1, "wr40");
    drive1(1'b0, 4'h0, 14'h0, 32'h0);
    drive0(1'b1, 4'h0, 14'h40, 32'h0);
    step(0, "rd40");
    drive0(1'b0, 4'h0, 14'h0, 32'h0);
    step(-1, "rd40 rsp");

    // ---- Write blocked by a port B read of the same word for 3 cycles ----
    drive1(1'b1, 4'b0011, 14'h20, 32'hA5A55A5A);
    driveB(1'b1, 4'h0, 14'h20);
    step(-1, "col c1");
    check("col stall1", 32'(stall_cnt), 32'd1);
    step(-1, "col c2");
    check("col stall2", 32'(stall_cnt), 32'd2);
    step(-1, "col c3");
    check("col stall3", 32'(stall_cnt), 32'd3);
    driveB(1'b0, 4'h0, 14'h0);
    step(1, "col c4");
    check("col stall held", 32'(stall_cnt), 32'd3);
    drive1(1'b0, 4'h0, 14'h0, 32'h0);
    step(-1, "col rsp");

    // ---- Requester 0 blocked by a port B write, requester 1 proceeds -----
    drive0(1'b1, 4'h0, 14'h24, 32'h0);
    drive1(1'b1, 4'h0, 14'h28, 32'h0);
    driveB(1'b1, 4'hF, 14'h24);
    step(1, "mix");
    check("mix stall", 32'(stall_cnt), 32'd4);
    drive1(1'b0, 4'h0, 14'h0, 32'h0);

    // ---- Blocked write withdrawn before it is accepted -------------------
    drive0(1'b1, 4'hF, 14'h24, 32'hFFFF0000);
    step(-1, "drop blk");
    check("drop stall", 32'(stall_cnt), 32'd5);
    drive0(1'b0, 4'h0, 14'h0, 32'h0);
    step(-1, "drop idle");
    check("drop stall held", 32'(stall_cnt), 32'd5);

    // ---- Read alongside a port B read of the same word: no collision -----
    driveB(1'b1, 4'h0, 14'h30);
    drive0(1'b1, 4'h0, 14'h30, 32'h0);
    step(0, "rdrd");
    check("rdrd stall", 32'(stall_cnt), 32'd5);
    drive0(1'b0, 4'h0, 14'h0, 32'h0);
    driveB(1'b0, 4'h0, 14'h0);
    step(-1, "rdrd rsp");

    // ---- Reset asserted while a granted access is in flight --------------
    drive0(1'b1, 4'h0, 14'h10, 32'h0);
    #1 check("mid grant ready0", 32'(req0_ready), 32'h1);
    #1 reset = 1'b1;
    #1;
    check("mid rst ready0",  32'(req0_ready), 32'h0);
    check("mid rst memC_en", 32'(memC_en),    32'h0);
    check("mid rst stall",   32'(stall_cnt),  32'h0);
    @(negedge clk);
    check("mid rst rsp0_valid", 32'(rsp0_valid), 32'h0);
    check("mid rst rsp0_rdata", rsp0_rdata,      32'h0);
    drive0(1'b0, 4'h0, 14'h0, 32'h0);
    reset = 1'b0;
    step(-1, "post rst1");
    step(-1, "post rst2");
    check("post rst stall", 32'(stall_cnt), 32'h0);

    // ---- Stall counter saturation -----------------------------------------
    drive0(1'b1, 4'h0, 14'h70, 32'h0);
    driveB(1'b1, 4'hF, 14'h70);
    for (int i = 0; i < 16'hFFFE; i++) @(negedge clk);
    check("sat fffe", 32'(stall_cnt), 32'hFFFE);
    check("sat memC_en", 32'(memC_en), 32'h0);
    @(negedge clk);
    check("sat ffff", 32'(stall_cnt), 32'hFFFF);
    @(negedge clk);
    check("sat hold", 32'(stall_cnt), 32'hFFFF);
    @(negedge clk);
    check("sat hold2", 32'(stall_cnt), 32'hFFFF);
    drive0(1'b0, 4'h0, 14'h0, 32'h0);
    driveB(1'b0, 4'h0, 14'h0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
